// File: rtl/lsu_byte_serial_if.sv
// Bundle of the MEM-stage request/response handshake and the byte-wide memory
// bus seen by lsu_byte_serial. The slave view belongs to the LSU itself.
interface lsu_byte_serial_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_sign;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  kill;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic [7:0]            mem_dout;
  logic [7:0]            mem_din;

  // master is the pipeline plus the external memory; slave is the LSU.
  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, kill, mem_din,
    input  req_ready, resp_valid, resp_rdata, busy, mem_a, mem_wr, mem_dout
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, kill, mem_din,
    output req_ready, resp_valid, resp_rdata, busy, mem_a, mem_wr, mem_dout
  );
endinterface

// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store unit: splits one 1/2/4/8-byte access into byte
// accesses, pipelines load addresses against READ_LATENCY, pulses completion.
module lsu_byte_serial #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  lsu_byte_serial_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STORE,
    S_LOAD,
    S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           nbytes_q, nbytes_d;
  logic [CW-1:0]           iss_q, iss_d;
  logic [CW-1:0]           cap_q, cap_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic                    rd_q, rd_d;
  logic                    sign_q, sign_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rbuf_q, rbuf_d;
  logic [ADDR_WIDTH-1:0]   mem_a_q, mem_a_d;
  logic                    mem_wr_q, mem_wr_d;
  logic [7:0]              mem_dout_q, mem_dout_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;

  logic                    idle_like;
  logic                    capture;
  logic                    fill;
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   extended;

  function automatic logic [CW-1:0] size_to_bytes(input logic [1:0] size);
    logic [CW-1:0] n;
    n = CW'(1) << size;
    if (n > CW'(NB)) n = CW'(NB);
    return n;
  endfunction

  assign idle_like = (state_q == S_IDLE) || (state_q == S_RESP);
  // pipe_q[i] set means the address issued i+1 cycles ago is still owed data.
  assign capture   = (state_q == S_LOAD) && pipe_q[READ_LATENCY-1];

  // Result assembly: drop the arriving byte into its lane, then extend.
  always_comb begin
    merged = rbuf_q;
    fill   = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (cap_q == CW'(i)) merged[8*i +: 8] = bus.mem_din;
    end
    for (int i = 0; i < NB; i++) begin
      if (nbytes_q == CW'(i + 1)) fill = merged[8*i + 7];
    end
    extended = merged;
    for (int i = 0; i < NB; i++) begin
      if (CW'(i) >= nbytes_q) extended[8*i +: 8] = {8{sign_q & fill}};
    end
  end

  // NOTE: every _d gets a default before the case so no path leaves a latch.
  always_comb begin
    state_d      = state_q;
    nbytes_d     = nbytes_q;
    iss_d        = iss_q;
    cap_d        = cap_q;
    pipe_d       = pipe_q;
    sign_d       = sign_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    resp_rdata_d = resp_rdata_q;
    rd_d         = 1'b0;
    mem_a_d      = '0;
    mem_wr_d     = 1'b0;
    mem_dout_d   = '0;
    resp_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_RESP: begin
        iss_d   = '0;
        cap_d   = '0;
        pipe_d  = '0;
        state_d = S_IDLE;
        if (bus.req_valid) begin
          nbytes_d = size_to_bytes(bus.req_size);
          sign_d   = bus.req_sign;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          rbuf_d   = '0;
          iss_d    = CW'(1);
          mem_a_d  = bus.req_addr;
          if (bus.req_we) begin
            state_d    = S_STORE;
            mem_wr_d   = 1'b1;
            mem_dout_d = bus.req_wdata[7:0];
          end else begin
            state_d = S_LOAD;
            rd_d    = 1'b1;
          end
        end
      end

      S_STORE: begin
        if (iss_q < nbytes_q) begin
          mem_a_d    = addr_q + ADDR_WIDTH'(iss_q);
          mem_wr_d   = 1'b1;
          mem_dout_d = 8'(wdata_q >> {iss_q, 3'b000});
          iss_d      = iss_q + CW'(1);
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
        end
      end

      S_LOAD: begin
        if (bus.kill) begin
          state_d = S_IDLE;
          iss_d   = '0;
          cap_d   = '0;
          pipe_d  = '0;
        end else begin
          pipe_d = (pipe_q << 1) | READ_LATENCY'(rd_q);
          if (iss_q < nbytes_q) begin
            mem_a_d = addr_q + ADDR_WIDTH'(iss_q);
            rd_d    = 1'b1;
            iss_d   = iss_q + CW'(1);
          end
          if (capture) begin
            rbuf_d = merged;
            cap_d  = cap_q + CW'(1);
            if (cap_q == nbytes_q - CW'(1)) begin
              state_d      = S_RESP;
              resp_valid_d = 1'b1;
              resp_rdata_d = extended;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      nbytes_q     <= '0;
      iss_q        <= '0;
      cap_q        <= '0;
      pipe_q       <= '0;
      rd_q         <= 1'b0;
      sign_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      mem_a_q      <= '0;
      mem_wr_q     <= 1'b0;
      mem_dout_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      nbytes_q     <= nbytes_d;
      iss_q        <= iss_d;
      cap_q        <= cap_d;
      pipe_q       <= pipe_d;
      rd_q         <= rd_d;
      sign_q       <= sign_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      mem_a_q      <= mem_a_d;
      mem_wr_q     <= mem_wr_d;
      mem_dout_q   <= mem_dout_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = idle_like;
  assign bus.busy       = !idle_like;
  assign bus.mem_a      = mem_a_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_dout   = mem_dout_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: doc/lsu_byte_serial.md
# lsu_byte_serial

Parametrised load/store unit that sits between the MEM pipeline stage and the byte-wide external memory bus. It serialises one load or store of 1, 2, 4 or 8 bytes into consecutive byte accesses and pipelines load addresses against a configurable memory read latency. Load results are returned little-endian with optional sign extension. A one-cycle completion pulse replaces the stall-until-done scheme of the previous stage.

## Interface
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, register data width; must be 32 or 64.
- READ_LATENCY, 2, number of cycles from a byte address being driven to its data appearing on mem_din; legal range 1..4.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  access request from the MEM stage.
- req_ready  out  1  unit idle; the request is accepted on an edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  log2 of the byte count: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_sign  in  1  sign-extend the load result.
- req_addr  in  ADDR_WIDTH  base byte address.
- req_wdata  in  DATA_WIDTH  store data; byte k is bits 8k+7:8k.
- kill  in  1  abort an in-flight load (pipeline flush).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  load result; 0 after a store.
- busy  out  1  equals !req_ready.
- mem_a  out  ADDR_WIDTH  byte address to memory.
- mem_wr  out  1  byte write strobe.
- mem_dout  out  8  byte write data.
- mem_din  in  8  byte read data.

## Operation
- Byte count N = 1 << req_size, clamped to DATA_WIDTH/8. A size of 3 at DATA_WIDTH=32 gives N=4.
- Request fields are latched at acceptance. Later changes on req_* have no effect until the next acceptance.
- States:
  - IDLE: req_ready=1. Acceptance goes to STORE or LOAD.
  - STORE: issue bytes k=0..N-1, one per cycle. mem_a=addr+k, mem_wr=1, mem_dout=wdata byte k. After the last byte, go to RESP.
  - LOAD: an issue counter drives mem_a=addr+k for k=0..N-1, with mem_wr=0. A separate capture counter samples mem_din into result byte k at the edge ending cycle (issue cycle of k)+READ_LATENCY. After the last capture, go to RESP.
  - RESP: resp_valid=1 for one cycle, then go to IDLE. req_ready=1 in RESP, so a back-to-back request is accepted on the RESP edge.
- Address arithmetic is modulo 2^ADDR_WIDTH; addr+k wraps through zero.
- Load result:
  - Bytes 0..N-1 are placed little-endian.
  - Upper bits are zero-filled, or filled with bit 8N-1 if req_sign=1.
  - req_sign is ignored when N = DATA_WIDTH/8.
- resp_rdata updates only in RESP and holds its value until the next RESP. A store's RESP drives 0.
- kill:
  - In LOAD: go to IDLE on the next edge, with no RESP and no resp_rdata update. Outstanding read data is discarded.
  - In STORE: ignored; the store always completes to avoid a partial write.
  - In IDLE or RESP: no effect.
- Outside STORE/LOAD: mem_a=0, mem_wr=0, mem_dout=0.

## Timing
- Reset (asynchronous, immediate, including mid-access): state IDLE, req_ready=1, busy=0, resp_valid=0, resp_rdata=0, mem_a=0, mem_wr=0, mem_dout=0, all counters 0. A partially issued store is truncated.
- Let E0 be the acceptance edge.
- Store: byte k is driven in the cycle after edge E_k. resp_valid is high in the cycle after E_N. Total N+1 cycles.
- Load: address k is driven after E_k, and byte k is captured at E_{k+READ_LATENCY+1}. resp_valid is high after E_{N+READ_LATENCY}. Total N+READ_LATENCY+1 cycles.
- All mem_* outputs and resp_* outputs are registered; there are no combinational paths from req_* or mem_din to outputs.
- kill and rst take priority over every other transition on the same edge.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF -> writes 0xEF@0x100, 0xBE@0x101, 0xAD@0x102, 0xDE@0x103 on 4 consecutive cycles; resp_valid in cycle 5; resp_rdata=0.
- LB with sign, addr=0x200 (memory byte 0x80), READ_LATENCY=2 -> resp_rdata=0xFFFFFF80 in cycle 4; the same access with LBU gives 0x00000080.
- LH addr=0xFFFFFFFF (wrap), memory 0x34@0xFFFFFFFF and 0x12@0x0 -> mem_a sequence is 0xFFFFFFFF then 0x0; resp_rdata=0x00001234.
- Back-to-back LW then SB with req_valid held -> second request accepted on the RESP edge of the first; no idle bubble; no byte dropped.
- kill one cycle into LW -> no resp_valid, resp_rdata unchanged, req_ready=1 next cycle. kill during SH -> both bytes written and resp_valid still issued.
- rst asserted mid-LW, between edges -> mem_a=0 and req_ready=1 immediately; after release, LW addr=0x10 completes normally.
